// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, scheduler FSM encoding and the grant-index width helper.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        ACK   = 3'd2,
        DONE  = 3'd3,
        GAP   = 3'd4
    } txState_t;

    // Index width for n items, never narrower than one bit.
    function automatic int gntW(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search starting after lastGrant; the caller owns the pointer.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]        req,
    input  logic [gntW(NUM_REQ)-1:0]  lastGrant,
    input  logic                      enable,
    output logic [NUM_REQ-1:0]        grant,
    output logic [gntW(NUM_REQ)-1:0]  grantIdx,
    output logic                      any
);

    localparam int GW = gntW(NUM_REQ);

    logic [2*NUM_REQ-1:0] reqDbl;
    logic [NUM_REQ-1:0]   reqRot;
    int                   pick;
    int                   winner;

    always_comb begin
        // Rotate so bit 0 is the requester right after the last grant.
        reqDbl   = {req, req} >> (int'(lastGrant) + 1);
        reqRot   = reqDbl[NUM_REQ-1:0];
        pick     = 0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (reqRot[j]) pick = j;
        end
        winner   = (int'(lastGrant) + 1 + pick) % NUM_REQ;
        any      = enable && (|reqRot);
        grant    = '0;
        grantIdx = '0;
        if (any) begin
            grant    = NUM_REQ'(1) << winner;
            grantIdx = GW'(winner);
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler feeding fixed-length messages from NUM_REQ requesters
// byte by byte into a shared UART transmitter over a tx_start/tx_busy handshake.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MSG_BYTES  = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*MSG_BYTES*8-1:0]    req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [BYTE_W-1:0]                 tx_data,
    output logic                              tx_start,
    input  logic                              tx_busy,
    output logic [gntW(NUM_REQ)-1:0]          grant_id,
    output logic                              active
);

    localparam int GW    = gntW(NUM_REQ);
    localparam int MSG_W = MSG_BYTES * BYTE_W;
    localparam int BIW   = gntW(MSG_BYTES);
    localparam int GCW   = gntW(GAP_CYCLES + 1);
    localparam logic [BIW-1:0] LAST_BYTE = BIW'(MSG_BYTES - 1);
    localparam logic [GCW-1:0] LAST_GAP  = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    txState_t            state, stateNxt;
    logic [GW-1:0]       lastGrant;
    logic [BIW-1:0]      byteIdx;
    logic [GCW-1:0]      gapCnt;
    logic [MSG_W-1:0]    msgBuf;
    logic [NUM_REQ-1:0]  arbGrant;
    logic [GW-1:0]       arbIdx;
    logic                arbAny;
    logic [NUM_REQ-1:0]  reqReadyNxt;
    logic                txStartNxt;
    logic [BYTE_W-1:0]   txDataNxt;
    logic                activeNxt;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) uArb (
        .req       (req_valid),
        .lastGrant (lastGrant),
        .enable    (state == IDLE),
        .grant     (arbGrant),
        .grantIdx  (arbIdx),
        .any       (arbAny)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        unique case (state)
            IDLE:    if (arbAny)   stateNxt = ISSUE;
            ISSUE:   if (!tx_busy) stateNxt = ACK;
            ACK:     if (tx_busy)  stateNxt = DONE;
            DONE: begin
                if (!tx_busy) begin
                    if (byteIdx == LAST_BYTE) stateNxt = (GAP_CYCLES > 0) ? GAP : IDLE;
                    else                      stateNxt = ISSUE;
                end
            end
            GAP:     if (gapCnt == LAST_GAP) stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    // active tracks "not heading back to IDLE", so it drops exactly when the FSM returns.
    always_comb begin
        reqReadyNxt = '0;
        txStartNxt  = 1'b0;
        txDataNxt   = tx_data;
        activeNxt   = (stateNxt != IDLE);
        if (state == IDLE && arbAny) reqReadyNxt = arbGrant;
        if (state == ISSUE && !tx_busy) begin
            txStartNxt = 1'b1;
            txDataNxt  = BYTE_W'(msgBuf >> (int'(byteIdx) * BYTE_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            grant_id  <= '0;
            active    <= 1'b0;
            lastGrant <= GW'(NUM_REQ - 1);
            byteIdx   <= '0;
            gapCnt    <= '0;
        end else begin
            req_ready <= reqReadyNxt;
            tx_start  <= txStartNxt;
            tx_data   <= txDataNxt;
            active    <= activeNxt;
            if (state == IDLE && arbAny) begin
                grant_id  <= arbIdx;
                lastGrant <= arbIdx;
                byteIdx   <= '0;
            end else if (state == DONE && stateNxt == ISSUE) begin
                byteIdx <= byteIdx + 1'b1;
            end
            if (state == DONE && stateNxt == GAP) gapCnt <= '0;
            else if (state == GAP)                gapCnt <= gapCnt + 1'b1;
        end
    end

    // Message payload is plain data; it is only meaningful after a capture.
    always_ff @(posedge clk) begin
        if (state == IDLE && arbAny) msgBuf <= MSG_W'(req_data >> (int'(arbIdx) * MSG_W));
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler with a behavioural transmitter and round-robin model.
module tb_uart_tx_scheduler;

    localparam int NR  = 4;
    localparam int MB  = 4;
    localparam int GAP = 5;
    localparam int DW  = NR * MB * 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [NR-1:0] req_valid = '0;
    logic [DW-1:0] req_data = '0;
    logic [NR-1:0] req_ready;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic [1:0]    grant_id;
    logic          active;

    uart_tx_scheduler #(.NUM_REQ(NR), .MSG_BYTES(MB), .GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .active    (active)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busyCnt = 0;
    logic forceBusy = 1'b0;

    // Transmitter: busy from the cycle after tx_start for 10 clocks; unaffected by scheduler reset.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_start)         busyCnt <= 10;
        else if (busyCnt > 0) busyCnt <= busyCnt - 1;
    end
    assign tx_busy = (busyCnt != 0) || forceBusy;

    logic [7:0] txByteQ[$];
    int         txGntQ[$];
    int         txCycQ[$];
    int         txLatQ[$];
    int         fallCycQ[$];
    int         readyCycQ[$];
    int         lastFall = 0;
    int         activeFallCyc = -1;
    logic       prevBusy = 1'b0;
    logic       prevActive = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (tx_start) begin
            txByteQ.push_back(tx_data);
            txGntQ.push_back(int'(grant_id));
            txCycQ.push_back(cyc);
            txLatQ.push_back(cyc - lastFall);
        end
        if (prevBusy && !tx_busy) begin
            lastFall = cyc;
            fallCycQ.push_back(cyc);
        end
        prevBusy = tx_busy;
        if (req_ready != 0) readyCycQ.push_back(cyc);
        if (prevActive && !active) activeFallCyc = cyc;
        prevActive = active;
    end

    // Reference model state
    logic [31:0] cur[NR];
    logic [7:0]  expQ[$];
    int          expGnt[$];
    int          modelLast;

    function automatic int rrPick(input logic [NR-1:0] v, input int last);
        logic [NR-1:0] s;
        rrPick = -1;
        for (int k = NR; k >= 1; k--) begin
            s = v >> ((last + k) % NR);
            if (s[0]) rrPick = (last + k) % NR;
        end
    endfunction

    task automatic setMsg(input int i, input logic [31:0] m);
        cur[i]   = m;
        req_data = (req_data & ~(DW'(32'hFFFF_FFFF) << (i * 32))) | (DW'(m) << (i * 32));
    endtask

    task automatic pushMsg(input logic [31:0] m);
        logic [31:0] t;
        for (int b = 0; b < MB; b++) begin
            t = m >> (8 * b);
            expQ.push_back(t[7:0]);
        end
    endtask

    task automatic clearMon();
        txByteQ.delete(); txGntQ.delete(); txCycQ.delete(); txLatQ.delete();
        fallCycQ.delete(); readyCycQ.delete(); expQ.delete(); expGnt.delete();
        activeFallCyc = -1;
    endtask

    task automatic waitReady(output bit ok);
        ok = 0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            ok = (req_ready != 0);
        end
    endtask

    task automatic waitActiveLow(output bit ok);
        ok = 0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            ok = !active;
        end
    endtask

    task automatic test_reset();
        bit ok;
        #1 rst_n = 1'b0;
        clearMon();
        req_valid = 4'b1111;
        for (int i = 0; i < NR; i++) setMsg(i, $urandom);
        repeat (4) @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", tx_data); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant: got %0d want 0", grant_id); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_active: got %b want 0", active); end
        checks++; if (txCycQ.size() != 0 || readyCycQ.size() != 0) begin
            errors++; $display("FAIL rst_quiet: got %0d starts %0d readies want 0", txCycQ.size(), readyCycQ.size());
        end
        modelLast = NR - 1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_ready: got %b want 0001", req_ready); end
        req_valid = '0;
        pushMsg(cur[0]);
        modelLast = 0;
        waitActiveLow(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_msg_timeout: got active=1 want 0"); end
        checks++; if (txByteQ.size() != expQ.size()) begin errors++; $display("FAIL rst_msg_count: got %0d want %0d", txByteQ.size(), expQ.size()); end
        for (int k = 0; k < expQ.size() && k < txByteQ.size(); k++) begin
            checks++; if (txByteQ[k] !== expQ[k]) begin errors++; $display("FAIL rst_msg_byte%0d: got %h want %h", k, txByteQ[k], expQ[k]); end
        end
    endtask

    task automatic test_single();
        bit ok;
        int i, e, rdy;
        logic [31:0] m;
        logic [NR-1:0] expV;
        for (int t = 0; t < 3; t++) begin
            clearMon();
            i = (t == 0) ? 2 : int'($urandom_range(0, NR - 1));
            m = (t == 0) ? 32'hA1B2C3D4 : $urandom;
            setMsg(i, m);
            req_valid = NR'(1) << i;
            e = rrPick(req_valid, modelLast);
            expV = NR'(1) << e;
            waitReady(ok);
            rdy = cyc;
            req_valid = '0;
            checks++; if (!ok) begin errors++; $display("FAIL single_ready_timeout: got none want %b", expV); end
            checks++; if (req_ready !== expV) begin errors++; $display("FAIL single_ready: got %b want %b", req_ready, expV); end
            checks++; if (grant_id !== 2'(e)) begin errors++; $display("FAIL single_grant: got %0d want %0d", grant_id, e); end
            modelLast = e;
            pushMsg(m);
            waitActiveLow(ok);
            checks++; if (!ok) begin errors++; $display("FAIL single_active_timeout: got 1 want 0"); end
            checks++; if (txByteQ.size() != MB) begin errors++; $display("FAIL single_count: got %0d want %0d", txByteQ.size(), MB); end
            for (int k = 0; k < MB && k < txByteQ.size(); k++) begin
                checks++; if (txByteQ[k] !== expQ[k] || txGntQ[k] != e) begin
                    errors++; $display("FAIL single_byte%0d: got %h/g%0d want %h/g%0d", k, txByteQ[k], txGntQ[k], expQ[k], e);
                end
                if (k > 0) begin
                    checks++; if (txLatQ[k] != 2) begin errors++; $display("FAIL single_interbyte%0d: got %0d want 2", k, txLatQ[k]); end
                end
            end
            if (txCycQ.size() > 0) begin
                checks++; if (txCycQ[0] - rdy != 1) begin errors++; $display("FAIL single_first_start: got %0d want 1", txCycQ[0] - rdy); end
            end
            // Last busy fall, then GAP cycles in GAP, then active drops entering IDLE.
            checks++; if (activeFallCyc - lastFall != GAP + 1) begin
                errors++; $display("FAIL single_active_fall: got %0d want %0d", activeFallCyc - lastFall, GAP + 1);
            end
        end
    endtask

    task automatic test_fairness();
        bit ok;
        int e;
        logic [NR-1:0] expV;
        clearMon();
        for (int i = 0; i < NR; i++) setMsg(i, $urandom);
        req_valid = '1;
        for (int n = 0; n < 8; n++) begin
            waitReady(ok);
            checks++; if (!ok) begin errors++; $display("FAIL fair_timeout%0d: got none want a ready", n); break; end
            e = rrPick(req_valid, modelLast);
            expV = NR'(1) << e;
            checks++; if (req_ready !== expV || $countones(req_ready) != 1) begin
                errors++; $display("FAIL fair_ready%0d: got %b want %b", n, req_ready, expV);
            end
            modelLast = e;
            expGnt.push_back(e);
            pushMsg(cur[e]);
            if (n == 7) req_valid = '0;
            else        setMsg(e, $urandom);
        end
        waitActiveLow(ok);
        checks++; if (txByteQ.size() != expQ.size()) begin errors++; $display("FAIL fair_count: got %0d want %0d", txByteQ.size(), expQ.size()); end
        for (int k = 0; k < expQ.size() && k < txByteQ.size(); k++) begin
            checks++; if (txByteQ[k] !== expQ[k] || txGntQ[k] != expGnt[k / MB]) begin
                errors++; $display("FAIL fair_byte%0d: got %h/g%0d want %h/g%0d", k, txByteQ[k], txGntQ[k], expQ[k], expGnt[k / MB]);
            end
        end
    endtask

    task automatic test_isolation();
        bit ok;
        clearMon();
        setMsg(1, $urandom);
        req_valid = 4'b0010;
        waitReady(ok);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL iso_ready1: got %b want 0010", req_ready); end
        modelLast = 1;
        pushMsg(cur[1]);
        // Held valid with new data: must not disturb the captured message, becomes the next one.
        setMsg(1, $urandom);
        setMsg(0, $urandom);
        setMsg(3, $urandom);
        repeat (5) @(negedge clk);
        setMsg(1, $urandom);
        waitReady(ok);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL iso_ready2: got %b want 0010", req_ready); end
        pushMsg(cur[1]);
        req_valid = '0;
        waitActiveLow(ok);
        checks++; if (readyCycQ.size() != 2) begin errors++; $display("FAIL iso_ready_count: got %0d want 2", readyCycQ.size()); end
        checks++; if (txByteQ.size() != expQ.size()) begin errors++; $display("FAIL iso_count: got %0d want %0d", txByteQ.size(), expQ.size()); end
        for (int k = 0; k < expQ.size() && k < txByteQ.size(); k++) begin
            checks++; if (txByteQ[k] !== expQ[k]) begin errors++; $display("FAIL iso_byte%0d: got %h want %h", k, txByteQ[k], expQ[k]); end
        end
    endtask

    task automatic test_gap_busy();
        bit ok;
        int r2, n0, rel;
        clearMon();
        setMsg(3, $urandom);
        req_valid = 4'b1000;
        waitReady(ok);
        pushMsg(cur[3]);
        setMsg(3, $urandom);
        waitReady(ok);
        r2 = cyc;
        pushMsg(cur[3]);
        req_valid = '0;
        checks++; if (fallCycQ.size() != MB) begin errors++; $display("FAIL gap_falls: got %0d want %0d", fallCycQ.size(), MB); end
        // Busy fall, GAP idle cycles, one IDLE cycle to arbitrate, then the ready pulse.
        if (fallCycQ.size() > 0) begin
            checks++; if (r2 - fallCycQ[fallCycQ.size() - 1] != GAP + 2) begin
                errors++; $display("FAIL gap_len: got %0d want %0d", r2 - fallCycQ[fallCycQ.size() - 1], GAP + 2);
            end
        end
        waitActiveLow(ok);
        setMsg(0, $urandom);
        req_valid = 4'b0001;
        waitReady(ok);
        pushMsg(cur[0]);
        req_valid = '0;
        forceBusy = 1'b1;
        n0 = txCycQ.size();
        repeat (20) @(negedge clk);
        checks++; if (txCycQ.size() != n0) begin errors++; $display("FAIL busy_hold: got %0d starts want 0", txCycQ.size() - n0); end
        forceBusy = 1'b0;
        rel = cyc;
        waitActiveLow(ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_timeout: got active=1 want 0"); end
        if (txCycQ.size() > n0) begin
            checks++; if (txCycQ[n0] - rel != 1) begin errors++; $display("FAIL busy_release: got %0d want 1", txCycQ[n0] - rel); end
        end
        checks++; if (txByteQ.size() != expQ.size()) begin errors++; $display("FAIL gap_count: got %0d want %0d", txByteQ.size(), expQ.size()); end
        for (int k = 0; k < expQ.size() && k < txByteQ.size(); k++) begin
            checks++; if (txByteQ[k] !== expQ[k]) begin errors++; $display("FAIL gap_byte%0d: got %h want %h", k, txByteQ[k], expQ[k]); end
        end
    endtask

    task automatic test_midreset();
        bit ok;
        logic [31:0] m1;
        clearMon();
        m1 = $urandom;
        setMsg(2, m1);
        req_valid = 4'b0100;
        waitReady(ok);
        req_valid = '0;
        pushMsg(m1);
        ok = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = (txCycQ.size() >= 2);
        end
        checks++; if (!ok) begin errors++; $display("FAIL mid_byte1_timeout: got %0d starts want 2", txCycQ.size()); end
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '1;
        for (int i = 0; i < NR; i++) setMsg(i, $urandom);
        repeat (3) @(negedge clk);
        checks++; if (tx_start !== 1'b0 || active !== 1'b0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL mid_rst_out: got start=%b active=%b ready=%b want 0 0 0000", tx_start, active, req_ready);
        end
        checks++; if (txByteQ.size() != 2) begin errors++; $display("FAIL mid_pre_count: got %0d want 2", txByteQ.size()); end
        for (int k = 0; k < 2 && k < txByteQ.size(); k++) begin
            checks++; if (txByteQ[k] !== expQ[k]) begin errors++; $display("FAIL mid_pre_byte%0d: got %h want %h", k, txByteQ[k], expQ[k]); end
        end
        clearMon();
        modelLast = NR - 1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001 || grant_id !== 2'd0) begin
            errors++; $display("FAIL mid_regrant: got %b/g%0d want 0001/g0", req_ready, grant_id);
        end
        req_valid = '0;
        pushMsg(cur[0]);
        waitActiveLow(ok);
        checks++; if (txByteQ.size() != MB) begin errors++; $display("FAIL mid_post_count: got %0d want %0d", txByteQ.size(), MB); end
        for (int k = 0; k < MB && k < txByteQ.size(); k++) begin
            checks++; if (txByteQ[k] !== expQ[k]) begin errors++; $display("FAIL mid_post_byte%0d: got %h want %h", k, txByteQ[k], expQ[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_isolation();
        test_gap_busy();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish before 300000");
        $fatal(1, "watchdog");
    end

endmodule
